// File: rtl/rom_access_ctrl_pkg.sv
// Shared definitions for the instruction-ROM access controller.
//   - state encodings used by the controller FSM
//   - requester port IDs (IF / LD), also the bit positions in the one-hot grant
//   - ROM byte size and an address legality helper
package rom_access_ctrl_pkg;

    localparam logic [1:0] _RAC_IDLE   = 2'd0;
    localparam logic [1:0] _RAC_ACCESS = 2'd1;
    localparam logic [1:0] _RAC_RESP   = 2'd2;

    localparam int unsigned _RAC_IF = 0;
    localparam int unsigned _RAC_LD = 1;

    localparam int unsigned _RAC_ROM_BYTES = 2048;

    typedef enum logic [1:0] {
        StIdle   = _RAC_IDLE,
        StAccess = _RAC_ACCESS,
        StResp   = _RAC_RESP
    } rac_state_e;

    // Word aligned and inside the ROM image.
    function automatic logic addr_valid(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < 32'(_RAC_ROM_BYTES));
    endfunction

endpackage

// File: rtl/rom_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (combinational).
//   i_req        : request vector, bit 0 = IF, bit 1 = LD
//   i_last_grant : port granted last time (0 = IF, 1 = LD)
//   i_enable     : allows a grant this cycle
//   o_grant      : one-hot grant, all-zero when disabled or idle
module rr_arb2
    import rom_access_ctrl_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            // On a tie the port that did not win last time is served.
            o_grant[_RAC_IF] = i_req[_RAC_IF] &
                               (~i_req[_RAC_LD] | (i_last_grant == 1'(_RAC_LD)));
            o_grant[_RAC_LD] = i_req[_RAC_LD] &
                               (~i_req[_RAC_IF] | (i_last_grant == 1'(_RAC_IF)));
        end
    end

endmodule

// File: rtl/rom_access_ctrl.sv
// Instruction-ROM access controller shared by instruction fetch (IF) and the
// data load path (LD). Converts byte addresses to word indices, holds the ROM
// enabled for WAIT_STATES+1 cycles, and returns registered data with a
// one-cycle ack. Misaligned / out-of-range addresses are answered with err
// without touching the ROM.
//   clk, rst              : clock, asynchronous active-high reset
//   if_* / ld_*           : req (level), byte addr, ack pulse, rdata, err
//   rom_nce/rom_re/rom_addr/rom_data : ROM interface (nce active-low)
//   busy                  : controller not idle
module rom_access_ctrl
    import rom_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic              rom_nce,
    output logic              rom_re,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    rac_state_e        r_state;
    rac_state_e        w_state_next;
    logic              r_last_grant;
    logic              r_gnt;          // port being served
    logic              r_err;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ld_rdata;

    logic [1:0]        w_grant;
    logic              w_grant_en;
    logic              w_access;
    logic              w_resp;
    logic [31:0]       w_sel_addr;
    logic              w_sel_valid;

    rr_arb2 u_arb (
        .i_req        ({ld_req, if_req}),
        .i_last_grant (r_last_grant),
        .i_enable     (w_grant_en),
        .o_grant      (w_grant)
    );

    assign w_sel_addr  = w_grant[_RAC_LD] ? ld_addr : if_addr;
    assign w_sel_valid = addr_valid(w_sel_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_access     = 1'b0;
        w_resp       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_grant_en = 1'b1;
                if (|w_grant) begin
                    w_state_next = w_sel_valid ? StAccess : StResp;
                end
            end
            StAccess: begin
                w_access = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_resp       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'(_RAC_LD);
            r_gnt        <= 1'(_RAC_IF);
            r_err        <= 1'b0;
            r_cnt        <= 4'd0;
            r_rom_addr   <= '0;
            r_if_rdata   <= '0;
            r_ld_rdata   <= '0;
        end else begin
            if (r_state == StIdle && (|w_grant)) begin
                r_gnt        <= w_grant[_RAC_LD];
                r_last_grant <= w_grant[_RAC_LD];
                r_err        <= ~w_sel_valid;
                if (w_sel_valid) begin
                    r_rom_addr <= w_sel_addr[ADDR_W+1:2];
                    r_cnt      <= 4'(WAIT_STATES);
                end else if (w_grant[_RAC_LD]) begin
                    r_ld_rdata <= '0;
                end else begin
                    r_if_rdata <= '0;
                end
            end else if (r_state == StAccess) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (r_gnt == 1'(_RAC_LD)) begin
                    r_ld_rdata <= rom_data;
                end else begin
                    r_if_rdata <= rom_data;
                end
            end
        end
    end

    assign rom_nce  = ~w_access;
    assign rom_re   = w_access;
    assign rom_addr = r_rom_addr;
    assign busy     = (r_state != StIdle);

    assign if_ack   = w_resp & (r_gnt == 1'(_RAC_IF));
    assign ld_ack   = w_resp & (r_gnt == 1'(_RAC_LD));
    assign if_err   = if_ack & r_err;
    assign ld_err   = ld_ack & r_err;
    assign if_rdata = r_if_rdata;
    assign ld_rdata = r_ld_rdata;

endmodule

// File: tb/tb_rom_access_ctrl.sv
module tb_rom_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic        if_ack, ld_ack, if_err, ld_err;
    logic [31:0] if_rdata, ld_rdata;
    logic        rom_nce, rom_re, busy;
    logic [8:0]  rom_addr;
    wire  [31:0] rom_data;

    // Second instance with WAIT_STATES=3; its LD port is idle.
    logic        if_req3;
    logic [31:0] if_addr3;
    logic        ld_req3;
    logic [31:0] ld_addr3;
    logic        if_ack3, ld_ack3, if_err3, ld_err3;
    logic [31:0] if_rdata3, ld_rdata3;
    logic        rom_nce3, rom_re3, busy3;
    logic [8:0]  rom_addr3;
    wire  [31:0] rom_data3;

    logic [31:0] mem [0:511];

    int checks   = 0;
    int failures = 0;
    int n_both, n_if_ack, n_ld_ack, n_nce_low, n_nce3_low;

    always #5 clk = ~clk;

    assign rom_data  = (!rom_nce && rom_re) ? mem[rom_addr] : 32'hzzzz_zzzz;
    assign rom_data3 = (!rom_nce3 && rom_re3) ? mem[rom_addr3] : 32'hzzzz_zzzz;

    rom_access_ctrl #(.WAIT_STATES(1), .ADDR_W(9), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ld_err(ld_err),
        .rom_nce(rom_nce), .rom_re(rom_re), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy)
    );

    rom_access_ctrl #(.WAIT_STATES(3), .ADDR_W(9), .DATA_W(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .if_err(if_err3),
        .ld_req(ld_req3), .ld_addr(ld_addr3), .ld_ack(ld_ack3), .ld_rdata(ld_rdata3),
        .ld_err(ld_err3),
        .rom_nce(rom_nce3), .rom_re(rom_re3), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .busy(busy3)
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (if_ack && ld_ack) n_both++;
        if (if_ack) n_if_ack++;
        if (ld_ack) n_ld_ack++;
        if (!rom_nce) n_nce_low++;
        if (!rom_nce3) n_nce3_low++;
    endtask

    task automatic clear_counts();
        n_both = 0; n_if_ack = 0; n_ld_ack = 0; n_nce_low = 0; n_nce3_low = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rom_nce !== 1'b1 || rom_re !== 1'b0 || rom_addr !== 9'd0) begin
            failures++;
            $display("FAIL reset_rom: nce=%b re=%b addr=%0d want nce=1 re=0 addr=0",
                     rom_nce, rom_re, rom_addr);
        end
        checks++;
        if (if_ack !== 1'b0 || ld_ack !== 1'b0 || if_err !== 1'b0 || ld_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: if_ack=%b ld_ack=%b if_err=%b ld_err=%b want all 0",
                     if_ack, ld_ack, if_err, ld_err);
        end
        checks++;
        if (if_rdata !== 32'd0 || ld_rdata !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: if_rdata=%h ld_rdata=%h busy=%b want 0 0 0",
                     if_rdata, ld_rdata, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_reads();
        clear_counts();
        if_req  = 1'b1;
        if_addr = 32'h0000_0000;
        tick();                               // edge T
        checks++;
        if (busy !== 1'b1 || rom_nce !== 1'b0 || rom_re !== 1'b1 || rom_addr !== 9'd0) begin
            failures++;
            $display("FAIL if0_access: busy=%b nce=%b re=%b addr=%0d want 1 0 1 0",
                     busy, rom_nce, rom_re, rom_addr);
        end
        tick();
        checks++;
        if (if_ack !== 1'b0 || rom_nce !== 1'b0) begin
            failures++;
            $display("FAIL if0_wait: if_ack=%b nce=%b want 0 0", if_ack, rom_nce);
        end
        tick();                               // cycle T+3
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h2001_0008 || if_err !== 1'b0) begin
            failures++;
            $display("FAIL if0_ack: ack=%b rdata=%h err=%b want 1 20010008 0",
                     if_ack, if_rdata, if_err);
        end
        if_addr = 32'h0000_0004;              // req stays high: back-to-back
        tick();
        checks++;
        if (busy !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h2001_0008) begin
            failures++;
            $display("FAIL if_idle_hold: busy=%b ack=%b rdata=%h want 0 0 20010008",
                     busy, if_ack, if_rdata);
        end
        tick();
        checks++;
        if (rom_addr !== 9'd1 || rom_nce !== 1'b0) begin
            failures++;
            $display("FAIL if1_addr: addr=%0d nce=%b want 1 0", rom_addr, rom_nce);
        end
        tick();
        tick();
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h1111_0001 || if_err !== 1'b0) begin
            failures++;
            $display("FAIL if1_ack: ack=%b rdata=%h err=%b want 1 11110001 0",
                     if_ack, if_rdata, if_err);
        end
        if_req = 1'b0;
        tick();
        tick();
        checks++;
        if (n_ld_ack !== 0 || n_if_ack !== 2) begin
            failures++;
            $display("FAIL if_ack_counts: ld_acks=%0d if_acks=%0d want 0 2", n_ld_ack, n_if_ack);
        end
    endtask

    task automatic test_round_robin();
        logic        order [0:3];
        logic [31:0] data [0:3];
        int          n = 0;
        do_reset();
        clear_counts();
        if_addr = 32'h0000_0008;
        ld_addr = 32'h0000_000C;
        if_req  = 1'b1;
        ld_req  = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (if_ack || ld_ack) begin
                order[n] = ld_ack;
                data[n]  = ld_ack ? ld_rdata : if_rdata;
                n++;
                if (n == 4) begin
                    if_req = 1'b0;
                    ld_req = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        ld_req = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rr_count: acks=%0d want 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (order[k] !== k[0] ||
                    data[k] !== (k[0] ? 32'h3333_0003 : 32'h2222_0002)) begin
                    failures++;
                    $display("FAIL rr_order%0d: port=%0d data=%h want port=%0d data=%h",
                             k, order[k], data[k], k[0],
                             k[0] ? 32'h3333_0003 : 32'h2222_0002);
                end
            end
        end
        tick();
        tick();
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL rr_both_acks: cycles=%0d want 0", n_both);
        end
    endtask

    task automatic test_errors();
        clear_counts();
        ld_req  = 1'b1;
        ld_addr = 32'h0000_0002;
        tick();                               // T+1: immediate response
        checks++;
        if (ld_ack !== 1'b1 || ld_err !== 1'b1 || ld_rdata !== 32'd0) begin
            failures++;
            $display("FAIL err_misalign: ack=%b err=%b rdata=%h want 1 1 0",
                     ld_ack, ld_err, ld_rdata);
        end
        ld_addr = 32'h0000_0800;
        tick();
        tick();
        checks++;
        if (ld_ack !== 1'b1 || ld_err !== 1'b1 || ld_rdata !== 32'd0) begin
            failures++;
            $display("FAIL err_range: ack=%b err=%b rdata=%h want 1 1 0",
                     ld_ack, ld_err, ld_rdata);
        end
        ld_req = 1'b0;
        tick();
        checks++;
        if (n_nce_low !== 0 || n_if_ack !== 0 || n_ld_ack !== 2 || if_err !== 1'b0) begin
            failures++;
            $display("FAIL err_side: nce_low=%0d if_acks=%0d ld_acks=%0d if_err=%b want 0 0 2 0",
                     n_nce_low, n_if_ack, n_ld_ack, if_err);
        end
    endtask

    task automatic test_wait3();
        int  ack_at = -1;
        int  addr_bad = 0;
        clear_counts();
        if_req3  = 1'b1;
        if_addr3 = 32'h0000_0010;
        for (int c = 1; c <= 12 && ack_at < 0; c++) begin
            tick();
            if (!rom_nce3 && rom_addr3 !== 9'd4) addr_bad++;
            if (if_ack3) begin
                ack_at = c;
                checks++;
                if (if_rdata3 !== 32'hCAFE_0004 || if_err3 !== 1'b0) begin
                    failures++;
                    $display("FAIL ws3_data: rdata=%h err=%b want cafe0004 0",
                             if_rdata3, if_err3);
                end
                if_req3 = 1'b0;
            end
        end
        if_req3 = 1'b0;
        checks++;
        if (ack_at != 5) begin
            failures++;
            $display("FAIL ws3_latency: ack cycle=%0d want 5", ack_at);
        end
        checks++;
        if (n_nce3_low !== 4 || addr_bad !== 0) begin
            failures++;
            $display("FAIL ws3_nce: low cycles=%0d addr glitches=%0d want 4 0",
                     n_nce3_low, addr_bad);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        clear_counts();
        if_req  = 1'b1;
        if_addr = 32'h0000_0014;
        tick();                               // in ACCESS now
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rom_nce !== 1'b1 || rom_re !== 1'b0 || rom_addr !== 9'd0 || busy !== 1'b0 ||
            if_rdata !== 32'd0 || if_ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: nce=%b re=%b addr=%0d busy=%b rdata=%h ack=%b want 1 0 0 0 0 0",
                     rom_nce, rom_re, rom_addr, busy, if_rdata, if_ack);
        end
        if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (n_if_ack !== 0) begin
            failures++;
            $display("FAIL abort_noack: if_acks=%0d want 0", n_if_ack);
        end
        if_req = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h5555_0005) begin
            failures++;
            $display("FAIL abort_retry: ack=%b rdata=%h want 1 55550005", if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        clear_counts();
        if_req  = 1'b1;
        if_addr = 32'h0000_0018;
        tick();                               // grant edge
        if_req  = 1'b0;
        if_addr = 32'h0000_001C;              // ignored: address latched at grant
        tick();
        tick();
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h6666_0006) begin
            failures++;
            $display("FAIL drop_ack: ack=%b rdata=%h want 1 66660006", if_ack, if_rdata);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || if_ack !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle: busy=%b ack=%b want 0 0", busy, if_ack);
        end
        tick();
        tick();
        checks++;
        if (n_if_ack !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_once: if_acks=%0d busy=%b want 1 0", n_if_ack, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[0] = 32'h2001_0008;
        mem[1] = 32'h1111_0001;
        mem[2] = 32'h2222_0002;
        mem[3] = 32'h3333_0003;
        mem[4] = 32'hCAFE_0004;
        mem[5] = 32'h5555_0005;
        mem[6] = 32'h6666_0006;
        mem[7] = 32'h7777_0007;
        rst      = 1'b1;
        if_req   = 1'b0;
        ld_req   = 1'b0;
        if_addr  = 32'd0;
        ld_addr  = 32'd0;
        if_req3  = 1'b0;
        if_addr3 = 32'd0;
        ld_req3  = 1'b0;
        ld_addr3 = 32'd0;
        clear_counts();

        test_reset();
        test_if_reads();
        test_round_robin();
        test_errors();
        test_wait3();
        test_reset_abort();
        test_req_drop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_access_ctrl.md
Name: rom_access_ctrl

Overview:
- Sequences all reads of the instruction ROM (512 x 32, active-low chip enable, read enable, word address, tristate data) and shares it between two requesters: instruction fetch (IF) and the data load path (LD) of the multi-cycle core.
- Converts byte addresses to word indices and inserts the configured ROM wait states.
- Arbitrates round-robin and returns registered read data over a req/ack handshake.
- Sits between the core control unit and the ROM.

Parameters:
- WAIT_STATES, 1, extra cycles rom_nce is held low before rom_data is sampled (0..15).
- ADDR_W, 9, ROM word-address width (512 words).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  IF read request (level).
- if_addr  in  32  IF byte address.
- if_ack  out  1  one-cycle pulse; if_rdata and if_err valid this cycle.
- if_rdata  out  32  IF read data, held until the next if_ack.
- if_err  out  1  IF address error, valid with if_ack.
- ld_req, ld_addr, ld_ack, ld_rdata, ld_err: same directions and widths as the IF set, for the LD port.
- rom_nce  out  1  ROM chip enable, active-low.
- rom_re  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM word address.
- rom_data  in  DATA_W  ROM data (tristate net).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is asynchronous, active-high, effective immediately.
  - state=IDLE, rom_nce=1, rom_re=0, rom_addr=0.
  - if_ack=ld_ack=0, if_err=ld_err=0, if_rdata=ld_rdata=0, busy=0.
  - last_grant=LD, so IF wins the first tie.
  - An in-flight access is dropped and no ack is issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on the rising edge with any req high, grant one port.
  - Only one requesting: grant it.
  - Both requesting: grant the port that is not last_grant; last_grant then updates to the granted port.
  - Latch the granted address.
  - Valid address: rom_addr <= addr[10:2], wait counter <= WAIT_STATES, next state ACCESS.
  - Invalid address (addr[1:0]!=0 or addr[31:11]!=0): no ROM access, error flag set, next state RESP.
- ACCESS: rom_nce=0, rom_re=1, rom_addr stable for the whole state.
  - Counter >0: decrement.
  - Counter ==0: capture rom_data into the granted port's rdata register (captured as-is, no Z/X filtering), next state RESP.
  - Duration is WAIT_STATES+1 cycles.
- RESP: rom_nce=1, rom_re=0. The granted port's ack is high for exactly one cycle with err valid; err=1 forces rdata=0. Next state IDLE.
- rdata is updated only at capture, or zeroed on error.
- Latency from the req-sampling edge T:
  - Valid read: ack during cycle T+WAIT_STATES+2 (T+3 at default).
  - Error: ack during cycle T+1.
- Handshake:
  - Requester holds req and addr stable until it sees ack.
  - req still high in the cycle after ack is treated as a new request, so back-to-back is legal.
  - Addr changes while the request is pending are ignored (address is latched at grant).
  - req dropped before ack: the access still completes and ack is still pulsed.
- Non-granted port: its req stays pending and is granted in the IDLE cycle after RESP; there is no starvation.
- Both acks are never high in the same cycle.
- rom_nce=0 and rom_re=1 occur only in ACCESS; they are deasserted together.

Decomposition:
- Shared defines file (alongside the existing opcode defines):
  - state encodings _RAC_IDLE/_RAC_ACCESS/_RAC_RESP.
  - port IDs _RAC_IF=0/_RAC_LD=1.
  - ROM byte size 2048.
- Sub-module rr_arb2: two-request round-robin grant.
  - Inputs: req[1:0], last_grant, enable. Output: one-hot grant.
  - Combinational; last_grant register stays in the parent.

Test Plan:
- Reset, then IF-only reads at 0x00 and 0x04 (ROM preloaded with 0x20010008 at word 0), WAIT_STATES=1 -> first if_ack at T+3 with if_rdata=0x20010008, if_err=0; rom_addr=0 then 1; ld_ack never asserts.
- if_req and ld_req asserted in the same cycle, held high for 4 transactions -> grant order IF, LD, IF, LD; no cycle with both acks high.
- ld_addr=0x00000002 (misaligned) and then 0x00000800 (out of range) -> ld_ack at T+1, ld_err=1, ld_rdata=0, rom_nce never low.
- WAIT_STATES=3, IF read of 0x10 -> rom_nce low for exactly 4 cycles, rom_addr=4 stable throughout, if_ack at T+5.
- rst pulsed during ACCESS -> outputs at reset values asynchronously, no ack for the aborted read; a fresh IF request after reset completes normally.
- if_req dropped one cycle after grant -> access still completes and if_ack pulses once; IDLE follows with busy=0.
